// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: pipeline stall/flush controller for the RV32 core.
// Merges NUM_SRC memory-ready sources, a redirect request and an external
// hold into one stall and one flush indication. After a redirect the
// controller drains FLUSH_CYCLES bubbles, then forces forward progress.
// Optional feature macro: STALL_PERF_CTR_EN enables the saturating stall and
// redirect performance counters; when undefined both perf outputs read 0.
module pipe_stall_ctrl #(
  parameter int NUM_SRC      = 2,
  parameter int FLUSH_CYCLES = 4,
  parameter int CTR_W        = 3,
  parameter int PERF_W       = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] mem_ready,
  input  logic               redirect_en,
  input  logic               hold_req,
  output logic               stall,
  output logic               flush,
  output logic               busy,
  output logic               pending_o,
  output logic [PERF_W-1:0]  perf_stall_cnt,
  output logic [PERF_W-1:0]  perf_redirect_cnt
);

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_DRAIN = 2'b01;
  localparam logic [1:0] ST_FORCE = 2'b10;
  localparam logic [1:0] ST_ILL   = 2'b11;

  localparam logic [CTR_W-1:0] CTR_LOAD = CTR_W'(FLUSH_CYCLES - 1);
  localparam logic [CTR_W-1:0] CTR_ONE  = CTR_W'(1);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CTR_W-1:0] ctr;
  logic [CTR_W-1:0] ctr_nxt;
  logic             pending;
  logic             pending_nxt;
  logic             enter_drain;
  logic             all_ready;

  assign all_ready = &mem_ready;

  // Stall: in FORCE_RUN a redirect must not stall so the pipe always advances.
  always_comb begin
    if (hold_req) begin
      stall = 1'b1;
    end else if (state == ST_FORCE) begin
      stall = ~all_ready;
    end else begin
      stall = redirect_en | ~all_ready;
    end
  end

  assign flush     = (state == ST_DRAIN);
  assign busy      = (state != ST_IDLE);
  assign pending_o = pending;

  // Next-state, drain counter and pending-redirect decision.
  always_comb begin
    state_nxt   = state;
    ctr_nxt     = ctr;
    pending_nxt = pending;
    enter_drain = 1'b0;
    if (hold_req) begin
      // Frozen; a redirect seen now is remembered for later service.
      if (redirect_en) begin
        pending_nxt = 1'b1;
      end else begin
        pending_nxt = pending;
      end
      if (state == ST_ILL) begin
        state_nxt = ST_IDLE;
      end else begin
        state_nxt = state;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          ctr_nxt = CTR_LOAD;
          if (redirect_en || pending) begin
            state_nxt   = ST_DRAIN;
            pending_nxt = 1'b0;
            enter_drain = 1'b1;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
        ST_DRAIN: begin
          if (redirect_en) begin
            ctr_nxt     = CTR_LOAD;
            enter_drain = 1'b1;
          end else if (ctr == '0) begin
            state_nxt = ST_FORCE;
            ctr_nxt   = CTR_LOAD;
          end else begin
            ctr_nxt = ctr - CTR_ONE;
          end
        end
        ST_FORCE: begin
          ctr_nxt = CTR_LOAD;
          if (redirect_en) begin
            pending_nxt = 1'b1;
          end else begin
            pending_nxt = pending;
          end
          if (all_ready) begin
            state_nxt = ST_IDLE;
          end else begin
            state_nxt = ST_FORCE;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          ctr_nxt   = CTR_LOAD;
        end
      endcase
    end
  end

  // Controller state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      ctr     <= CTR_LOAD;
      pending <= 1'b0;
    end else begin
      state   <= state_nxt;
      ctr     <= ctr_nxt;
      pending <= pending_nxt;
    end
  end

`ifdef STALL_PERF_CTR_EN
  logic [PERF_W-1:0] stall_cnt;
  logic [PERF_W-1:0] redirect_cnt;

  // Saturating counters of stall cycles and drain entries/restarts.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt    <= '0;
      redirect_cnt <= '0;
    end else begin
      if (stall && !(&stall_cnt)) begin
        stall_cnt <= stall_cnt + PERF_W'(1);
      end
      if (enter_drain && !(&redirect_cnt)) begin
        redirect_cnt <= redirect_cnt + PERF_W'(1);
      end
    end
  end

  assign perf_stall_cnt    = stall_cnt;
  assign perf_redirect_cnt = redirect_cnt;
`else
  assign perf_stall_cnt    = '0;
  assign perf_redirect_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed testbench for pipe_stall_ctrl (default parameters).
// Each step drives inputs shortly after a rising edge, then compares
// {stall, flush, busy, pending_o} and the perf counters against
// hand-computed values before the next edge.
module tb_pipe_stall_ctrl;

  logic        clk;
  logic        reset;
  logic [1:0]  mem_ready;
  logic        redirect_en;
  logic        hold_req;
  logic        stall;
  logic        flush;
  logic        busy;
  logic        pending_o;
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_redirect_cnt;

  int checks = 0;
  int errors = 0;

`ifdef STALL_PERF_CTR_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  pipe_stall_ctrl #(
    .NUM_SRC(2), .FLUSH_CYCLES(4), .CTR_W(3), .PERF_W(32)
  ) dut (
    .clk(clk),
    .reset(reset),
    .mem_ready(mem_ready),
    .redirect_en(redirect_en),
    .hold_req(hold_req),
    .stall(stall),
    .flush(flush),
    .busy(busy),
    .pending_o(pending_o),
    .perf_stall_cnt(perf_stall_cnt),
    .perf_redirect_cnt(perf_redirect_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic h, input logic [1:0] m);
    redirect_en = r;
    hold_req    = h;
    mem_ready   = m;
    #1;
  endtask

  // exp = {stall, flush, busy, pending_o}
  task automatic chk(input string tag, input logic [3:0] exp);
    logic [3:0] obs;
    obs = {stall, flush, busy, pending_o};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_perf(input string tag, input logic [31:0] obs, input int val);
    logic [31:0] exp;
    exp = PERF_ON ? 32'(val) : 32'd0;
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, 1'b0, 2'b11);
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    redirect_en = 1'b0;
    hold_req    = 1'b0;
    mem_ready   = 2'b11;
    tick();
    tick();
    reset = 1'b0;

    // 1: idle with all sources ready
    drive(1'b0, 1'b0, 2'b11);
    chk_perf("t1_perf_stall_rst", perf_stall_cnt, 0);
    chk_perf("t1_perf_redir_rst", perf_redirect_cnt, 0);
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b0, 2'b11);
      chk("t1_idle", 4'b0000);
      tick();
    end
    // not-ready source stalls in IDLE
    drive(1'b0, 1'b0, 2'b10);
    chk("t1_not_ready", 4'b1000);
    tick();

    // 2: single redirect -> 4 drain cycles, 1 force cycle, idle
    do_reset();
    drive(1'b1, 1'b0, 2'b11);
    chk("t2_redirect", 4'b1000);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 2'b11);
      chk("t2_drain", 4'b0110);
      tick();
    end
    drive(1'b0, 1'b0, 2'b11);
    chk("t2_force", 4'b0010);
    tick();
    drive(1'b0, 1'b0, 2'b11);
    chk("t2_idle", 4'b0000);
    tick();

    // 3: redirect in DRAIN at ctr=1 restarts the drain
    do_reset();
    drive(1'b1, 1'b0, 2'b11);
    tick();
    drive(1'b0, 1'b0, 2'b11);
    chk("t3_drain_c3", 4'b0110);
    tick();
    drive(1'b0, 1'b0, 2'b11);
    chk("t3_drain_c2", 4'b0110);
    tick();
    drive(1'b1, 1'b0, 2'b11);
    chk("t3_restart_c1", 4'b1110);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 2'b11);
      chk("t3_redrain", 4'b0110);
      tick();
    end
    drive(1'b0, 1'b0, 2'b11);
    chk("t3_force", 4'b0010);
    chk_perf("t3_perf_redir", perf_redirect_cnt, 2);
    chk_perf("t3_perf_stall", perf_stall_cnt, 2);
    tick();

    // 4: FORCE_RUN with partial ready and a redirect
    do_reset();
    drive(1'b1, 1'b0, 2'b11);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 2'b11);
      tick();
    end
    drive(1'b1, 1'b0, 2'b01);
    chk("t4_force_redir", 4'b1010);
    tick();
    drive(1'b0, 1'b0, 2'b01);
    chk("t4_force_wait1", 4'b1011);
    tick();
    drive(1'b0, 1'b0, 2'b01);
    chk("t4_force_wait2", 4'b1011);
    tick();
    drive(1'b0, 1'b0, 2'b11);
    chk("t4_force_ready", 4'b0011);
    tick();
    drive(1'b0, 1'b0, 2'b11);
    chk("t4_idle_pending", 4'b0001);
    tick();
    drive(1'b0, 1'b0, 2'b11);
    chk("t4_pending_drain", 4'b0110);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 2'b11);
      tick();
    end
    // redirect in FORCE_RUN with all ready never stalls
    drive(1'b1, 1'b0, 2'b11);
    chk("t4_force_nostall", 4'b0010);
    tick();
    drive(1'b0, 1'b0, 2'b11);
    chk("t4_idle_pending2", 4'b0001);
    tick();

    // 5: hold for 5 cycles in DRAIN at ctr=2
    do_reset();
    drive(1'b1, 1'b0, 2'b11);
    tick();
    drive(1'b0, 1'b0, 2'b11);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, 2'b11);
      chk("t5_hold", 4'b1110);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 2'b11);
      chk("t5_resume", 4'b0110);
      tick();
    end
    drive(1'b0, 1'b0, 2'b11);
    chk("t5_force", 4'b0010);
    tick();

    // 6: reset in DRAIN with pending set
    do_reset();
    drive(1'b1, 1'b0, 2'b11);
    chk("t6_redirect", 4'b1000);
    tick();
    drive(1'b1, 1'b1, 2'b11);
    chk("t6_hold_redir", 4'b1110);
    tick();
    drive(1'b0, 1'b0, 2'b11);
    chk("t6_drain_pending", 4'b0111);
    chk_perf("t6_perf_stall", perf_stall_cnt, 2);
    chk_perf("t6_perf_redir", perf_redirect_cnt, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive(1'b0, 1'b0, 2'b11);
    chk("t6_after_reset", 4'b0000);
    chk_perf("t6_perf_stall_clr", perf_stall_cnt, 0);
    chk_perf("t6_perf_redir_clr", perf_redirect_cnt, 0);
    tick();
    drive(1'b0, 1'b0, 2'b11);
    chk("t6_stays_idle", 4'b0000);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
